// File: rtl/npu_booth_mac_seq_pkg.sv
// Shared types for the Booth MAC sequencer: FSM state encoding, Booth digit codes
// and the digits-per-product derivation.
package npu_booth_mac_seq_pkg;

   typedef enum logic [1:0] {
      NPU_MAC_IDLE = 2'd0,
      NPU_MAC_MUL  = 2'd1,
      NPU_MAC_OUT  = 2'd2
   } state_t;

   // Booth digit code: [2] = negate, [1:0] = magnitude
   localparam int unsigned BOOTH_NEG   = 2;
   localparam logic [1:0]  BOOTH_MAG_0 = 2'd0;
   localparam logic [1:0]  BOOTH_MAG_1 = 2'd1;
   localparam logic [1:0]  BOOTH_MAG_2 = 2'd2;

   function automatic int booth_ndig(input int dwb);
      return dwb / 2 + 1;
   endfunction

   function automatic logic [2:0] booth_code(input logic [2:0] win);
      logic [2:0] code;
      case (win)
         3'b001, 3'b010: code = {1'b0, BOOTH_MAG_1};
         3'b011:         code = {1'b0, BOOTH_MAG_2};
         3'b100:         code = {1'b1, BOOTH_MAG_2};
         3'b101, 3'b110: code = {1'b1, BOOTH_MAG_1};
         default:        code = {1'b0, BOOTH_MAG_0};
      endcase
      return code;
   endfunction

endpackage

// File: rtl/npu_booth_mac_seq_if.sv
// Operand / result handshake bundle between cube operand fetch, the MAC lane and writeback.
interface npu_booth_mac_seq_if #(
   parameter int DWA = 8,
   parameter int DWB = 8,
   parameter int DWS = 21
);
   logic           in_valid;
   logic           in_ready;
   logic [DWA-1:0] in_a;
   logic [DWB-1:0] in_b;
   logic           in_signed;
   logic           in_last;
   logic           out_valid;
   logic           out_ready;
   logic [DWS-1:0] out_sum;
   logic           busy;

   modport master (
      output in_valid, in_a, in_b, in_signed, in_last, out_ready,
      input  in_ready, out_valid, out_sum, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_signed, in_last, out_ready,
      output in_ready, out_valid, out_sum, busy
   );
endinterface

// File: rtl/npu_booth_pp_gen.sv
// Radix-4 Booth partial-product generator: one digit window in, pp (pre carry-in),
// negate carry-in and the inverted-MSB sign-extension word out.
module npu_booth_pp_gen
   import npu_booth_mac_seq_pkg::*;
#(
   parameter int DWPPLEN = 10
) (
   input  logic [DWPPLEN-1:0] a_ext,
   input  logic [2:0]         win,
   output logic [DWPPLEN-1:0] pp,
   output logic               neg,
   output logic [DWPPLEN-1:0] se_word
);
   logic [2:0]         code;
   logic [DWPPLEN-1:0] mag;

   always_comb begin
      code = booth_code(win);
      case (code[1:0])
         BOOTH_MAG_1: mag = a_ext;
         BOOTH_MAG_2: mag = {a_ext[DWPPLEN-2:0], 1'b0};
         default:     mag = '0;
      endcase
      neg     = code[BOOTH_NEG];
      // negation finishes with neg as a carry-in in the accumulator add
      pp      = neg ? ~mag : mag;
      se_word = {~pp[DWPPLEN-1], pp[DWPPLEN-2:0]};
   end
endmodule

// File: rtl/npu_booth_mac_seq.sv
// Iterative radix-4 Booth MAC sequencer, one digit per cycle, dot product over a vector.
// Define NPU_MAC_SAT_EN for per-element products with saturating accumulation; default wraps.
//
//  state | meaning
//  IDLE  | waiting for an operand pair; accumulator holds any open vector
//  MUL   | one Booth digit per cycle, NDIG cycles per element
//  OUT   | out_sum valid, held until out_ready
module npu_booth_mac_seq
   import npu_booth_mac_seq_pkg::*;
#(
   parameter int DWA     = 8,
   parameter int DWB     = 8,
   parameter int DWS     = 21,
   parameter int DWPPLEN = DWA + 2
) (
   input  logic               clk,
   input  logic               rst,
   npu_booth_mac_seq_if.slave bus
);
   localparam int NDIG = booth_ndig(DWB);
   localparam int DCW  = $clog2(NDIG);
   localparam logic [DCW-1:0] LAST_DIG = DCW'(NDIG - 1);
`ifdef NPU_MAC_SAT_EN
   localparam int TW = DWA + DWB + 2;
`else
   localparam int TW = DWS;
`endif
   localparam logic [TW-1:0] SE_CORR = {TW{1'b1}} << (DWPPLEN - 1);

   state_t             state_q, state_d;
   logic [DCW-1:0]     dig_cnt;
   logic [DWPPLEN-1:0] a_ext;
   logic [DWB+2:0]     b_sh;
   logic               last_q;
   logic [DWS-1:0]     acc;
   logic [DWS-1:0]     acc_nx;
   logic               in_ready, out_valid, busy;
   logic               accept, last_dig, out_hs;
   logic [DWPPLEN-1:0] pp, se_word;
   logic               neg;
   logic [TW-1:0]      term;
   logic               unused_pp;

   assign accept   = bus.in_valid & in_ready;
   assign last_dig = (state_q == NPU_MAC_MUL) && (dig_cnt == LAST_DIG);
   assign out_hs   = out_valid & bus.out_ready;

   npu_booth_pp_gen #(.DWPPLEN(DWPPLEN)) u_pp_gen (
      .a_ext   (a_ext),
      .win     (b_sh[2:0]),
      .pp      (pp),
      .neg     (neg),
      .se_word (se_word)
   );

   // se_word carries everything pp does; pp stays as a debug tap
   assign unused_pp = ^pp;

   // Inverted-MSB scheme: the sign-extension ones come back in as the constant SE_CORR
   assign term = (TW'(se_word) + SE_CORR + TW'(neg)) << {dig_cnt, 1'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= NPU_MAC_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         NPU_MAC_IDLE: if (bus.in_valid) state_d = NPU_MAC_MUL;
         NPU_MAC_MUL: begin
            if (last_dig) begin
               if (last_q)             state_d = NPU_MAC_OUT;
               else if (!bus.in_valid) state_d = NPU_MAC_IDLE;
            end
         end
         NPU_MAC_OUT: if (bus.out_ready) state_d = NPU_MAC_IDLE;
         default: state_d = NPU_MAC_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         NPU_MAC_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         NPU_MAC_MUL: in_ready  = last_dig & ~last_q;
         NPU_MAC_OUT: out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.out_sum   = out_valid ? acc : '0;

`ifdef NPU_MAC_SAT_EN
   localparam logic [DWS-1:0] ACC_MAX = {1'b0, {(DWS-1){1'b1}}};
   localparam logic [DWS-1:0] ACC_MIN = {1'b1, {(DWS-1){1'b0}}};

   logic [TW-1:0] prod_q, prod_nx;
   logic [DWS:0]  sat_sum;

   always_comb begin
      prod_nx = ((dig_cnt == '0) ? '0 : prod_q) + term;
      sat_sum = {acc[DWS-1], acc} + {{(DWS+1-TW){prod_nx[TW-1]}}, prod_nx};
      if (sat_sum[DWS] != sat_sum[DWS-1]) acc_nx = sat_sum[DWS] ? ACC_MIN : ACC_MAX;
      else                                acc_nx = sat_sum[DWS-1:0];
   end
`else
   assign acc_nx = acc + term;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dig_cnt <= '0;
         a_ext   <= '0;
         b_sh    <= '0;
         last_q  <= 1'b0;
         acc     <= '0;
`ifdef NPU_MAC_SAT_EN
         prod_q  <= '0;
`endif
      end else begin
         if (state_q == NPU_MAC_MUL) begin
            dig_cnt <= last_dig ? '0 : dig_cnt + 1'b1;
            b_sh    <= b_sh >> 2;
`ifdef NPU_MAC_SAT_EN
            prod_q  <= prod_nx;
            if (last_dig) acc <= acc_nx;
`else
            acc     <= acc_nx;
`endif
         end
         if (accept) begin
            a_ext   <= {{2{bus.in_signed & bus.in_a[DWA-1]}}, bus.in_a};
            b_sh    <= {{2{bus.in_signed & bus.in_b[DWB-1]}}, bus.in_b, 1'b0};
            last_q  <= bus.in_last;
            dig_cnt <= '0;
         end
         if (out_hs) acc <= '0;
      end
   end
endmodule

// File: tb/tb_npu_booth_mac_seq.sv
// Self-checking bench for npu_booth_mac_seq: randomized vectors against an
// arithmetic dot-product model (wrapping, or saturating when NPU_MAC_SAT_EN is defined).
module tb_npu_booth_mac_seq;
   localparam int DWA  = 8;
   localparam int DWB  = 8;
   localparam int DWS  = 21;
   localparam int NDIG = DWB / 2 + 1;
   localparam int LAT  = NDIG + 1;
   localparam longint SUM_HI = (longint'(1) <<< (DWS - 1)) - 1;
   localparam longint SUM_LO = -(longint'(1) <<< (DWS - 1));

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   npu_booth_mac_seq_if #(.DWA(DWA), .DWB(DWB), .DWS(DWS)) bus ();

   npu_booth_mac_seq #(.DWA(DWA), .DWB(DWB), .DWS(DWS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [DWA-1:0] va[$];
   logic [DWB-1:0] vb[$];
   bit             vs[$];
   int             acc_cyc[$];

   function automatic longint elem_prod(input logic [DWA-1:0] a, input logic [DWB-1:0] b, input bit s);
      longint x, y;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      return x * y;
   endfunction

   function automatic logic [DWS-1:0] model_sum();
      logic [DWS-1:0] w;
      longint p;
`ifdef NPU_MAC_SAT_EN
      longint s_acc;
      s_acc = 0;
`endif
      w = '0;
      for (int i = 0; i < va.size(); i++) begin
         p = elem_prod(va[i], vb[i], vs[i]);
`ifdef NPU_MAC_SAT_EN
         s_acc = s_acc + p;
         if (s_acc > SUM_HI)      s_acc = SUM_HI;
         else if (s_acc < SUM_LO) s_acc = SUM_LO;
`else
         w = w + DWS'(p);
`endif
      end
`ifdef NPU_MAC_SAT_EN
      w = DWS'(s_acc);
`endif
      return w;
   endfunction

   task automatic clear_vec();
      va.delete(); vb.delete(); vs.delete();
   endtask

   task automatic push_elem(input logic [DWA-1:0] a, input logic [DWB-1:0] b, input bit s);
      va.push_back(a); vb.push_back(b); vs.push_back(s);
   endtask

   task automatic build_random(input int len);
      clear_vec();
      for (int i = 0; i < len; i++)
         push_elem(DWA'($urandom), DWB'($urandom), 1'($urandom_range(0, 1)));
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_signed = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   // Called and returns on a falling edge; records the cycle of every acceptance.
   task automatic send_vector(input bit hold_valid, input int max_gap, output bit ok);
      int guard;
      ok = 1'b1;
      acc_cyc.delete();
      for (int i = 0; i < va.size(); i++) begin
         bus.in_valid  = 1'b1;
         bus.in_a      = va[i];
         bus.in_b      = vb[i];
         bus.in_signed = vs[i];
         bus.in_last   = (i == va.size() - 1);
         guard = 0;
         while (!bus.in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
         end
         if (!bus.in_ready) begin
            ok = 1'b0;
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         acc_cyc.push_back(cyc);
         @(negedge clk);
         if (!hold_valid || i == va.size() - 1) begin
            bus.in_valid = 1'b0;
            if (i != va.size() - 1) repeat ($urandom_range(0, max_gap)) @(negedge clk);
         end
      end
   endtask

   // lat counts falling edges from acceptance of the last element to out_valid.
   task automatic get_result(input int stall, output logic [DWS-1:0] sum, output int lat, output bit ok);
      lat = 1;
      ok  = 1'b0;
      sum = '0;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.out_valid) return;
      repeat (stall) @(negedge clk);
      sum = bus.out_sum;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      ok = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_cmp++; if (bus.out_sum !== '0) begin n_err++; $display("FAIL reset_out_sum: got 0x%h expected 0", bus.out_sum); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [DWS-1:0] exp, sum;
      int lat;
      bit ok;
      clear_vec();
      push_elem(8'h80, 8'h80, 1'b1);
      exp = model_sum();
      send_vector(1'b1, 0, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL single_accept: got no handshake expected one"); end
      for (int k = 1; k < LAT; k++) begin
         n_cmp++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_mul_window T+%0d: got rdy=%b vld=%b busy=%b expected 0 0 1",
                     k, bus.in_ready, bus.out_valid, bus.busy);
         end
         @(negedge clk);
      end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid T+%0d: got %b expected 1", LAT, bus.out_valid); end
      n_cmp++; if (bus.out_sum !== exp) begin n_err++; $display("FAIL single_sum: got %0d expected %0d", $signed(bus.out_sum), $signed(exp)); end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL single_after_hs: got vld=%b busy=%b rdy=%b expected 0 0 1", bus.out_valid, bus.busy, bus.in_ready);
      end

      for (int s = 0; s < 2; s++) begin
         clear_vec();
         push_elem(8'hFF, 8'hFF, 1'(s));
         exp = model_sum();
         send_vector(1'b1, 0, ok);
         get_result(0, sum, lat, ok);
         n_cmp++; if (!ok || sum !== exp) begin n_err++; $display("FAIL ff_sum signed=%0d: got %0d expected %0d", s, sum, exp); end
         n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL ff_latency signed=%0d: got %0d expected %0d", s, lat, LAT); end
      end
   endtask

   task automatic test_back_to_back();
      logic [DWS-1:0] exp, sum;
      int lat;
      bit ok;
      for (int v = 0; v < 4; v++) begin
         if (v == 0) begin
            clear_vec();
            push_elem(8'd3, 8'd4, 1'b1);
            push_elem(8'hFB, 8'd6, 1'b1);
            push_elem(8'd7, 8'hF8, 1'b1);
            push_elem(8'd127, 8'd127, 1'b1);
         end else begin
            build_random($urandom_range(2, 8));
         end
         exp = model_sum();
         send_vector(1'b1, 0, ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_accept vec=%0d: got stall expected all accepted", v); end
         for (int i = 1; i < acc_cyc.size(); i++) begin
            n_cmp++;
            if (acc_cyc[i] - acc_cyc[i-1] !== NDIG) begin
               n_err++;
               $display("FAIL b2b_spacing vec=%0d el=%0d: got %0d expected %0d", v, i, acc_cyc[i] - acc_cyc[i-1], NDIG);
            end
         end
         get_result(0, sum, lat, ok);
         n_cmp++; if (!ok || sum !== exp) begin n_err++; $display("FAIL b2b_sum vec=%0d: got %0d expected %0d", v, $signed(sum), $signed(exp)); end
      end
   endtask

   task automatic test_out_stall();
      logic [DWS-1:0] exp, sum;
      int lat, guard;
      bit ok;
      build_random(3);
      exp = model_sum();
      send_vector(1'b1, 0, ok);
      guard = 0;
      while (!bus.out_valid && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_wait: got out_valid=%b expected 1", bus.out_valid); end
      bus.in_valid  = 1'b1;
      bus.in_a      = 8'h55;
      bus.in_b      = 8'h66;
      bus.in_signed = 1'b1;
      bus.in_last   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         n_cmp++;
         if (bus.out_sum !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold k=%0d: got sum=%0d rdy=%b vld=%b expected %0d 0 1",
                     k, $signed(bus.out_sum), bus.in_ready, bus.out_valid, $signed(exp));
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL stall_release: got vld=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
      end
      build_random(2);
      exp = model_sum();
      send_vector(1'b1, 0, ok);
      get_result(0, sum, lat, ok);
      n_cmp++; if (!ok || sum !== exp) begin n_err++; $display("FAIL stall_clean_sum: got %0d expected %0d", $signed(sum), $signed(exp)); end
   endtask

   task automatic test_saturation();
      logic [DWS-1:0] exp, sum;
      int lat;
      bit ok;
      for (int c = 0; c < 3; c++) begin
         clear_vec();
         case (c)
            0: repeat (64) push_elem(8'h80, 8'h80, 1'b1);
            1: repeat (17) push_elem(8'hFF, 8'hFF, 1'b0);
            default: repeat (70) push_elem(8'h80, 8'h7F, 1'b1);
         endcase
         exp = model_sum();
         send_vector(1'b1, 0, ok);
         get_result(0, sum, lat, ok);
         n_cmp++; if (!ok || sum !== exp) begin n_err++; $display("FAIL sat_sum case=%0d: got %0d expected %0d", c, $signed(sum), $signed(exp)); end
      end
   endtask

   task automatic test_gap();
      logic [DWS-1:0] exp, sum;
      int lat;
      bit ok;
      clear_vec();
      push_elem(8'd100, 8'hFD, 1'b1);
      push_elem(8'd200, 8'd250, 1'b0);
      exp = model_sum();
      bus.in_valid  = 1'b1;
      bus.in_a      = va[0];
      bus.in_b      = vb[0];
      bus.in_signed = vs[0];
      bus.in_last   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (NDIG + 1) @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL gap_idle: got busy=%b rdy=%b vld=%b expected 0 1 0", bus.busy, bus.in_ready, bus.out_valid);
      end
      repeat (3) @(negedge clk);
      void'(va.pop_front()); void'(vb.pop_front()); void'(vs.pop_front());
      send_vector(1'b1, 0, ok);
      get_result(0, sum, lat, ok);
      n_cmp++; if (!ok || sum !== exp) begin n_err++; $display("FAIL gap_sum: got %0d expected %0d", $signed(sum), $signed(exp)); end
   endtask

   task automatic test_reset_mid();
      logic [DWS-1:0] exp, sum;
      int lat, guard;
      bit ok;
      bus.in_valid  = 1'b1;
      bus.in_a      = 8'd50;
      bus.in_b      = 8'd60;
      bus.in_signed = 1'b1;
      bus.in_last   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_enter: got busy=%b expected 1", bus.busy); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_sum !== '0) begin
         n_err++;
         $display("FAIL rstmid_mul: got rdy=%b vld=%b busy=%b sum=0x%h expected 1 0 0 0",
                  bus.in_ready, bus.out_valid, bus.busy, bus.out_sum);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
         clear_vec();
         push_elem(8'd2, 8'd3, 1'b1);
         exp = model_sum();
         send_vector(1'b1, 0, ok);
         get_result(0, sum, lat, ok);
         n_cmp++; if (!ok || sum !== exp) begin n_err++; $display("FAIL rstmid_next_sum r=%0d: got %0d expected %0d", r, $signed(sum), $signed(exp)); end
         if (r == 0) begin
            clear_vec();
            push_elem(8'd90, 8'd77, 1'b0);
            push_elem(8'd11, 8'd13, 1'b0);
            send_vector(1'b1, 0, ok);
            guard = 0;
            while (!bus.out_valid && guard < 40) begin
               @(negedge clk);
               guard++;
            end
            rst = 1'b1;
            #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.busy !== 1'b0) begin
               n_err++;
               $display("FAIL rstmid_out: got vld=%b sum=0x%h busy=%b expected 0 0 0", bus.out_valid, bus.out_sum, bus.busy);
            end
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_random();
      logic [DWS-1:0] exp, sum;
      int lat;
      bit ok;
      for (int v = 0; v < 10; v++) begin
         build_random($urandom_range(1, 6));
         exp = model_sum();
         send_vector(1'($urandom_range(0, 1)), 3, ok);
         get_result($urandom_range(0, 4), sum, lat, ok);
         n_cmp++; if (!ok || sum !== exp) begin n_err++; $display("FAIL rand_sum vec=%0d: got %0d expected %0d", v, $signed(sum), $signed(exp)); end
         n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rand_out_drop vec=%0d: got %b expected 0", v, bus.out_valid); end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_back_to_back();
      test_out_stall();
      test_saturation();
      test_gap();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by time %0t expected completion", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
